// File: rtl/ose_encoder_gen.sv
// ose_encoder_gen: quadrature A/B detent generator with valid/ready commands,
// programmable phase length and LFSR-driven contact chatter on the changed line.
module ose_encoder_gen #(
  parameter int PHASE_TICKS  = 4,
  parameter int BOUNCE_TICKS = 0,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_abort,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done
);
  localparam logic [1:0]  IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2;
  localparam logic [15:0] PT_LAST = 16'(PHASE_TICKS - 1);
  localparam logic [15:0] BT = 16'(BOUNCE_TICKS);
  logic [1:0] state, state_n, phase, phase_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [15:0] tick, tick_n;
  logic [7:0] lfsr, lfsr_n;
  logic dir, abort_pend, abort_n, ca, cb, ca_n, cb_n, ma, mb, ma_n, mb_n, done_n;
  logic accept, wrap, last, bnc;
  assign accept = cmd_valid & cmd_ready;
  assign wrap = tick == PT_LAST;
  assign last = (cnt == CNT_W'(1)) | abort_pend | cmd_abort;
  assign bnc = tick_n < BT;
  assign lfsr_n = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  // ca/cb are the clean quadrature levels; ma/mb mark the line that changed in this phase
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    tick_n = wrap ? 16'd0 : tick + 16'd1;
    phase_n = phase;
    abort_n = abort_pend;
    ca_n = ca;
    cb_n = cb;
    ma_n = ma;
    mb_n = mb;
    done_n = 1'b0;
    if (state == IDLE) begin
      tick_n = 16'd0;
      if (accept) begin
        state_n = (cmd_count == '0) ? HOLD : RUN;
        cnt_n = cmd_count;
        phase_n = 2'd0;
        abort_n = 1'b0;
        ma_n = 1'b0;
        mb_n = 1'b0;
      end
    end else if (state == RUN) begin
      abort_n = abort_pend | cmd_abort;
      if (wrap) begin
        phase_n = phase + 2'd1;
        ca_n = dir ? ^phase_n : phase_n[1];
        cb_n = dir ? phase_n[1] : ^phase_n;
        ma_n = ca_n ^ ca;
        mb_n = cb_n ^ cb;
        if (phase == 2'd3) begin
          cnt_n = last ? '0 : cnt - CNT_W'(1);
          state_n = last ? HOLD : RUN;
        end
      end
    end else if (wrap) begin
      state_n = IDLE;
      done_n = 1'b1;
      ma_n = 1'b0;
      mb_n = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      dir <= 1'b0;
      cnt <= '0;
      tick <= 16'd0;
      phase <= 2'd0;
      abort_pend <= 1'b0;
      ca <= 1'b0;
      cb <= 1'b0;
      ma <= 1'b0;
      mb <= 1'b0;
      lfsr <= 8'hA5;
      a <= 1'b0;
      b <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      dir <= accept ? cmd_dir : dir;
      cnt <= cnt_n;
      tick <= tick_n;
      phase <= phase_n;
      abort_pend <= abort_n;
      ca <= ca_n;
      cb <= cb_n;
      ma <= ma_n;
      mb <= mb_n;
      lfsr <= lfsr_n;
      a <= ca_n ^ (ma_n & bnc & lfsr_n[0]);
      b <= cb_n ^ (mb_n & bnc & lfsr_n[0]);
      done <= done_n;
    end
  end
endmodule
